// File: rtl/i2s_master_stereo.sv
// Stereo I2S bus master: generates bclk/lrclk, serializes a 16-bit L/R pair on tx
// and deserializes rx into a L/R pair every 64-bit frame.
module i2s_master_stereo #(
  parameter int unsigned DIVW = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic [DIVW-1:0] div,
  input  logic [4:0]      align,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [15:0]     tx_left,
  input  logic [15:0]     tx_right,
  output logic            bclk,
  output logic            lrclk,
  output logic            tx,
  input  logic            rx,
  output logic            rx_valid,
  output logic [15:0]     rx_left,
  output logic [15:0]     rx_right,
  output logic            underrun
);

  localparam int unsigned SW = 16;
  localparam int unsigned BW = 6;

  logic [DIVW-1:0] cnt, div_q;
  logic [BW-1:0]   bcnt;
  logic            hold_full, primed;
  logic [SW-1:0]   hold_l, hold_r;
  logic [SW-1:0]   tx_sh_l, tx_sh_r;
  logic [SW-1:0]   rx_sh_l, rx_sh_r;

  logic            wrap, rise_ev, fall_ev, boundary, win_c, win_n, tx_bit;
  logic [BW-1:0]   bcnt_n;
  logic [4:0]      a_eff, pos_c, pos_n, off_c, off_n;
  logic [3:0]      bit_n;
  logic [SW-1:0]   ld_l, ld_r, ch_n;

  assign tx_ready = enable & ~hold_full;

  // Event decode and the tx bit for the slot position about to be entered
  always_comb begin
    wrap     = (cnt == div_q);
    rise_ev  = wrap & ~bclk;
    fall_ev  = wrap & bclk;
    bcnt_n   = bcnt + BW'(1);
    boundary = fall_ev & (bcnt_n == '0);
    a_eff    = (align > 5'd16) ? 5'd16 : align;
    pos_c    = bcnt[4:0];
    pos_n    = bcnt_n[4:0];
    off_c    = pos_c - a_eff;
    off_n    = pos_n - a_eff;
    win_c    = (pos_c >= a_eff) && (off_c <= 5'd15);
    win_n    = (pos_n >= a_eff) && (off_n <= 5'd15);
    ld_l     = tx_sh_l;
    ld_r     = tx_sh_r;
    if (boundary) begin
      ld_l = hold_full ? hold_l : '0;
      ld_r = hold_full ? hold_r : '0;
    end
    ch_n   = bcnt_n[5] ? ld_r : ld_l;
    bit_n  = 4'd15 - off_n[3:0];
    tx_bit = win_n ? ch_n[bit_n] : 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      div_q     <= '0;
      bcnt      <= '1;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      primed    <= 1'b0;
      tx_sh_l   <= '0;
      tx_sh_r   <= '0;
      rx_sh_l   <= '0;
      rx_sh_r   <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      tx        <= 1'b0;
      rx_valid  <= 1'b0;
      rx_left   <= '0;
      rx_right  <= '0;
      underrun  <= 1'b0;
    end else if (!enable) begin
      // Disabled: hold everything at reset values; div is tracked so the first half period is exact
      cnt       <= '0;
      div_q     <= div;
      bcnt      <= '1;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      primed    <= 1'b0;
      tx_sh_l   <= '0;
      tx_sh_r   <= '0;
      rx_sh_l   <= '0;
      rx_sh_r   <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      tx        <= 1'b0;
      rx_valid  <= 1'b0;
      rx_left   <= '0;
      rx_right  <= '0;
      underrun  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      if (wrap) begin
        cnt   <= '0;
        div_q <= div;
        bclk  <= ~bclk;
      end else begin
        cnt <= cnt + DIVW'(1);
      end
      if (fall_ev) begin
        bcnt  <= bcnt_n;
        lrclk <= bcnt_n[5];
        tx    <= tx_bit;
      end
      if (rise_ev && win_c) begin
        if (bcnt[5]) rx_sh_r <= {rx_sh_r[SW-2:0], rx};
        else         rx_sh_l <= {rx_sh_l[SW-2:0], rx};
      end
      // Frame boundary: reload tx pair, publish previous frame's rx pair
      if (boundary) begin
        tx_sh_l  <= ld_l;
        tx_sh_r  <= ld_r;
        underrun <= ~hold_full;
        if (hold_full) hold_full <= 1'b0;
        if (primed) begin
          rx_left  <= rx_sh_l;
          rx_right <= rx_sh_r;
          rx_valid <= 1'b1;
        end
        primed <= 1'b1;
      end
      if (tx_valid && tx_ready) begin
        hold_full <= 1'b1;
        hold_l    <= tx_left;
        hold_r    <= tx_right;
      end
    end
  end

endmodule
